ysyx_23060020_lsu: RTL
======================

// Module: ysyx_23060020_lsu
// PURPOSE
//  Load/store unit: the initiator side of the data-memory interface.
//  Accepts one load/store op at a time from EXU over valid/ready, then drives a word-aligned memory request.
//  Stores carry a byte mask; for loads it extracts and sign/zero-extends the returned lane.
//  Reports misalignment, illegal funct3 and response timeout as an error on the writeback handshake.
// PARAMETERS
//  RESP_TIMEOUT  255  max cycles waiting in RESP before abort with error; 0 = no timeout
// PORTS
//  clk             in   1   clock; all state updates on rising edge
//  rst             in   1   synchronous, active-high reset
//  in_valid        in   1   EXU op valid
//  in_ready        out  1   LSU can accept op (high only in IDLE)
//  in_wen          in   1   1 = store, 0 = load
//  in_funct3       in   3   RV32 funct3: 0 b, 1 h, 2 w, 4 bu, 5 hu
//  in_addr         in   32  byte address
//  in_wdata        in   32  store data (low bytes significant)
//  mem_req_valid   out  1   memory request valid
//  mem_req_ready   in   1   memory accepts request
//  mem_req_wen     out  1   request is a write
//  mem_req_addr    out  32  {addr[31:2],2'b00}
//  mem_req_wdata   out  32  lane-replicated store data
//  mem_req_wmask   out  4   byte enables (0 for loads)
//  mem_resp_valid  in   1   response/ack valid (one cycle)
//  mem_resp_rdata  in   32  read word
//  out_valid       out  1   result valid to WBU
//  out_ready       in   1   WBU accepts result
//  out_rdata       out  32  extended load data; 0 for stores and errors
//  out_err         out  1   op failed (misaligned/illegal/timeout)
// BEHAVIOUR
//  States IDLE, REQ, RESP, DONE. rst -> IDLE; timer=0; all req/out regs 0.
//  in_ready = (state==IDLE) & ~rst. All other outputs registered or state-decoded; 0 in IDLE.
//  IDLE: on in_valid: latch wen/funct3/addr/wdata.
//   Illegal (load funct3 3/6/7, store funct3 >2) or misaligned (h & addr[0]; w & addr[1:0]!=0)
//   -> DONE with err=1, rdata=0, no memory request issued. Else -> REQ.
//  REQ: mem_req_valid=1; addr/wen/wdata/wmask stable until mem_req_ready; on handshake -> RESP, timer=0.
//  Masks: sb 4'b0001<<a[1:0]; sh 4'b0011<<a[1:0]; sw 4'hF. wdata: sb {4{b}}, sh {2{h}}, sw word.
//  RESP: mem_resp_valid sampled only here (earliest the cycle after the REQ handshake).
//   On valid: load rdata = (mem_resp_rdata >> 8*a[1:0]), then sign/zero-extend per funct3; store rdata=0.
//   -> DONE with err=0.
//   Else timer++. If RESP_TIMEOUT!=0 and timer==RESP_TIMEOUT-1: -> DONE err=1 rdata=0.
//  DONE: out_valid=1; rdata/err stable until out_ready; on handshake -> IDLE (next op accepted the following cycle).
//  Latency: in handshake at T; mem_req_valid at T+1; with ready=1 and 1-cycle response, out_valid at T+3.
//  Single outstanding op; in_valid ignored outside IDLE.
//  mem_resp_valid seen in IDLE/REQ/DONE is ignored, including a late response after a timeout.
//  rst mid-operation: abandon op immediately and drop mem_req_valid/out_valid next cycle; no completion reported.
//  Timer width $clog2(RESP_TIMEOUT+1) (min 1); saturates and never wraps.
// TESTING
//  lw a=0x80000004, resp 0xDEADBEEF -> req addr 0x80000004 wmask 0, out_rdata 0xDEADBEEF err 0
//  lb a=0x80000003, resp 0x80FFFFFF -> out_rdata 0xFFFFFF80; lbu same -> 0x00000080
//  sh a=0x80000002 wdata 0x1234ABCD -> wmask 4'b1100, wdata 0xABCDABCD, out_rdata 0 err 0
//  lw a=0x80000002 -> no mem_req_valid, out_valid with err=1 one cycle after accept
//  mem_req_ready low 5 cycles -> req fields stable; RESP_TIMEOUT=4, no resp -> err=1 after 4 cycles
//  rst pulsed while in RESP, then late mem_resp_valid -> ignored, in_ready=1, no out_valid

Source files
------------

// File: rtl/ysyx_23060020_lsu.sv
// rtl/ysyx_23060020_lsu.sv - load/store unit: EXU op in, word-aligned data-memory request out, extended result to WBU
module ysyx_23060020_lsu #(
  parameter int RESP_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        in_wen,
  input  logic [2:0]  in_funct3,
  input  logic [31:0] in_addr,
  input  logic [31:0] in_wdata,
  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic        mem_req_wen,
  output logic [31:0] mem_req_addr,
  output logic [31:0] mem_req_wdata,
  output logic [3:0]  mem_req_wmask,
  input  logic        mem_resp_valid,
  input  logic [31:0] mem_resp_rdata,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_rdata,
  output logic        out_err
);
  localparam int TW = (RESP_TIMEOUT > 0) ? $clog2(RESP_TIMEOUT + 1) : 1;
  localparam logic [TW-1:0] T_LAST = TW'((RESP_TIMEOUT > 0) ? RESP_TIMEOUT - 1 : 0);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_RESP, S_DONE} state_e;

  state_e          state_q, state_d;
  logic            wen_q, wen_d;
  logic [2:0]      funct3_q, funct3_d;
  logic [31:0]     addr_q, addr_d;
  logic [31:0]     wdata_q, wdata_d;
  logic [31:0]     rdata_q, rdata_d;
  logic            err_q, err_d;
  logic [TW-1:0]   timer_q, timer_d;

  logic            in_illegal, in_misaligned;
  logic [31:0]     lane, lane_ext, rep_wdata;
  logic [3:0]      byte_mask;
  logic            in_req, in_done;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      wen_q    <= 1'b0;
      funct3_q <= 3'd0;
      addr_q   <= 32'd0;
      wdata_q  <= 32'd0;
      rdata_q  <= 32'd0;
      err_q    <= 1'b0;
      timer_q  <= '0;
    end else begin
      state_q  <= state_d;
      wen_q    <= wen_d;
      funct3_q <= funct3_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
      timer_q  <= timer_d;
    end
  end

  // Op legality is judged on the incoming fields so a bad op never reaches REQ.
  always_comb begin
    in_illegal = in_wen ? (in_funct3 > 3'd2)
                        : (in_funct3 == 3'd3 || in_funct3 == 3'd6 || in_funct3 == 3'd7);
    in_misaligned = ((in_funct3[1:0] == 2'd1) && in_addr[0]) ||
                    ((in_funct3 == 3'd2) && (in_addr[1:0] != 2'd0));
  end

  always_comb begin
    lane = mem_resp_rdata >> {addr_q[1:0], 3'b000};
    case (funct3_q)
      3'd0:    lane_ext = {{24{lane[7]}}, lane[7:0]};
      3'd4:    lane_ext = {24'd0, lane[7:0]};
      3'd1:    lane_ext = {{16{lane[15]}}, lane[15:0]};
      3'd5:    lane_ext = {16'd0, lane[15:0]};
      default: lane_ext = lane;
    endcase
    case (funct3_q[1:0])
      2'd0: begin
        byte_mask = 4'b0001 << addr_q[1:0];
        rep_wdata = {4{wdata_q[7:0]}};
      end
      2'd1: begin
        byte_mask = 4'b0011 << addr_q[1:0];
        rep_wdata = {2{wdata_q[15:0]}};
      end
      default: begin
        byte_mask = 4'hF;
        rep_wdata = wdata_q;
      end
    endcase
  end

  always_comb begin
    state_d  = state_q;
    wen_d    = wen_q;
    funct3_d = funct3_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
    err_d    = err_q;
    timer_d  = timer_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          wen_d    = in_wen;
          funct3_d = in_funct3;
          addr_d   = in_addr;
          wdata_d  = in_wdata;
          rdata_d  = 32'd0;
          err_d    = in_illegal || in_misaligned;
          state_d  = (in_illegal || in_misaligned) ? S_DONE : S_REQ;
        end
      end
      S_REQ: begin
        if (mem_req_ready) begin
          state_d = S_RESP;
          timer_d = '0;
        end
      end
      S_RESP: begin
        if (mem_resp_valid) begin
          rdata_d = wen_q ? 32'd0 : lane_ext;
          err_d   = 1'b0;
          state_d = S_DONE;
        end else if (RESP_TIMEOUT != 0 && timer_q == T_LAST) begin
          rdata_d = 32'd0;
          err_d   = 1'b1;
          state_d = S_DONE;
        end else if (timer_q != '1) begin
          timer_d = timer_q + 1'b1;
        end
      end
      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    in_req        = (state_q == S_REQ);
    in_done       = (state_q == S_DONE);
    in_ready      = (state_q == S_IDLE) && !rst;
    mem_req_valid = in_req;
    mem_req_wen   = in_req && wen_q;
    mem_req_addr  = in_req ? {addr_q[31:2], 2'b00} : 32'd0;
    mem_req_wdata = (in_req && wen_q) ? rep_wdata : 32'd0;
    mem_req_wmask = (in_req && wen_q) ? byte_mask : 4'd0;
    out_valid     = in_done;
    out_rdata     = in_done ? rdata_q : 32'd0;
    out_err       = in_done && err_q;
  end
endmodule
